// File: rtl/diff_demo_pkg.sv
// Shared types and constants for the PE partial-sum collector.
package diff_demo_pkg;

  // Width of one PE partial-sum element.
  localparam int PSUM_WIDTH = 16;

  // Tile geometry of one PE FIFO word.
  localparam int TILE_ROWS = 3;
  localparam int TILE_COLS = 6;

  // Collector control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    CAPT = 2'd2,
    OUT  = 2'd3
  } collector_state_t;

endpackage

// File: rtl/psum_collector_requant_unit.sv
// One-element requantizer.
// Arithmetic right shift, then saturation to signed 8 bits.
// Build option PSUM_COLLECTOR_RELU_EN clamps negative results to zero.
module requant_unit
  import diff_demo_pkg::*;
#(
  parameter int ACC_WIDTH = PSUM_WIDTH + 8
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  input  logic        [4:0]           shift,
  output logic        [7:0]           q
);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(8'sd127);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  // Clamp a wide signed value into the signed 8-bit range.
  function automatic logic [7:0] sat8(input logic signed [ACC_WIDTH-1:0] v);
    logic [7:0] r;
    if (v > SAT_MAX) begin
      r = 8'h7F;
    end else if (v < SAT_MIN) begin
      r = 8'h80;
    end else begin
      r = v[7:0];
    end
    return r;
  endfunction

  logic signed [ACC_WIDTH-1:0] shifted_s;
  logic        [7:0]           sat_s;

  // Shift, saturate and optionally rectify one accumulator element.
  always_comb begin
    shifted_s = acc >>> shift;
    sat_s     = sat8(shifted_s);
`ifdef PSUM_COLLECTOR_RELU_EN
    if (sat_s[7]) begin
      q = 8'h00;
    end else begin
      q = sat_s;
    end
`else
    q = sat_s;
`endif
  end

endmodule

// File: rtl/psum_collector.sv
// Partial-sum collector.
// Pops one 3x6 psum tile per input-channel pass from a PE FIFO and accumulates the tiles.
// Requantizes the result and streams it out as 3 rows of 6 int8 activations.
// Optional macro PSUM_COLLECTOR_RELU_EN enables ReLU after saturation.
module psum_collector
  import diff_demo_pkg::*;
#(
  parameter int PSUM_WIDTH = diff_demo_pkg::PSUM_WIDTH,
  parameter int ACC_WIDTH  = PSUM_WIDTH + 8,
  parameter int PASS_W     = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [PASS_W-1:0]                      cfg_num_pass,
  input  logic [4:0]                             cfg_shift,
  output logic                                   busy_o,
  input  logic                                   fifo_empty_i,
  input  logic [TILE_ROWS*TILE_COLS*PSUM_WIDTH-1:0] fifo_dout_i,
  output logic                                   fifo_rd_en_o,
  output logic                                   act_valid_o,
  input  logic                                   act_ready_i,
  output logic [TILE_COLS*8-1:0]                 act_data_o,
  output logic [1:0]                             act_row_o,
  output logic                                   done_o
);

  localparam int NUM_ELEM = TILE_ROWS * TILE_COLS;

  collector_state_t            state_r;
  logic [PASS_W-1:0]           num_pass_r;
  logic [PASS_W-1:0]           pass_cnt_r;
  logic [4:0]                  shift_r;
  logic                        rd_wait_r;  // 0: pop in flight, 1: FIFO data valid this cycle
  logic signed [ACC_WIDTH-1:0] acc_r [NUM_ELEM];

  logic signed [ACC_WIDTH-1:0] psum_ext_s [NUM_ELEM];
  logic signed [ACC_WIDTH-1:0] row_acc_s  [TILE_COLS];
  logic                        handshake_s;
  logic [1:0]                  row_sel_s;
  logic [TILE_COLS*8-1:0]      req_row_s;

  // Sign-extend every FIFO element to accumulator width.
  always_comb begin
    for (int k = 0; k < NUM_ELEM; k++) begin
      psum_ext_s[k] = {{(ACC_WIDTH-PSUM_WIDTH){fifo_dout_i[k*PSUM_WIDTH + PSUM_WIDTH-1]}},
                       fifo_dout_i[k*PSUM_WIDTH +: PSUM_WIDTH]};
    end
  end

  // Detect an output handshake and pick the row the requant path presents next.
  always_comb begin
    if ((state_r == OUT) && act_valid_o && act_ready_i) begin
      handshake_s = 1'b1;
      if (act_row_o != 2'd2) begin
        row_sel_s = act_row_o + 2'd1;
      end else begin
        row_sel_s = act_row_o;
      end
    end else begin
      handshake_s = 1'b0;
      row_sel_s   = act_row_o;
    end
  end

  // Select the accumulator row feeding the requant units.
  always_comb begin
    for (int c = 0; c < TILE_COLS; c++) begin
      case (row_sel_s)
        2'd0:    row_acc_s[c] = acc_r[c];
        2'd1:    row_acc_s[c] = acc_r[TILE_COLS + c];
        2'd2:    row_acc_s[c] = acc_r[2*TILE_COLS + c];
        default: row_acc_s[c] = acc_r[c];
      endcase
    end
  end

  for (genvar c = 0; c < TILE_COLS; c++) begin : g_requant
    requant_unit #(
      .ACC_WIDTH(ACC_WIDTH)
    ) u_requant (
      .acc   (row_acc_s[c]),
      .shift (shift_r),
      .q     (req_row_s[c*8 +: 8])
    );
  end

  // Control FSM, accumulators and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      num_pass_r   <= '0;
      pass_cnt_r   <= '0;
      shift_r      <= 5'd0;
      rd_wait_r    <= 1'b0;
      busy_o       <= 1'b0;
      fifo_rd_en_o <= 1'b0;
      act_valid_o  <= 1'b0;
      act_data_o   <= '0;
      act_row_o    <= 2'd0;
      done_o       <= 1'b0;
      for (int k = 0; k < NUM_ELEM; k++) begin
        acc_r[k] <= '0;
      end
    end else begin
      done_o       <= 1'b0;
      fifo_rd_en_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            num_pass_r <= (cfg_num_pass == '0) ? PASS_W'(1) : cfg_num_pass;
            shift_r    <= cfg_shift;
            pass_cnt_r <= '0;
            busy_o     <= 1'b1;
            state_r    <= POP;
            for (int k = 0; k < NUM_ELEM; k++) begin
              acc_r[k] <= '0;
            end
          end
        end
        POP: begin
          if (!fifo_empty_i) begin
            fifo_rd_en_o <= 1'b1;
            rd_wait_r    <= 1'b0;
            state_r      <= CAPT;
          end
        end
        CAPT: begin
          if (!rd_wait_r) begin
            rd_wait_r <= 1'b1;
          end else begin
            rd_wait_r <= 1'b0;
            for (int k = 0; k < NUM_ELEM; k++) begin
              acc_r[k] <= acc_r[k] + psum_ext_s[k];
            end
            pass_cnt_r <= pass_cnt_r + PASS_W'(1);
            if ((pass_cnt_r + PASS_W'(1)) == num_pass_r) begin
              act_row_o <= 2'd0;
              state_r   <= OUT;
            end else begin
              state_r <= POP;
            end
          end
        end
        OUT: begin
          // First OUT cycle loads row 0 once the final accumulation has settled.
          if (!act_valid_o) begin
            act_valid_o <= 1'b1;
            act_data_o  <= req_row_s;
          end else if (handshake_s) begin
            if (act_row_o == 2'd2) begin
              act_valid_o <= 1'b0;
              done_o      <= 1'b1;
              busy_o      <= 1'b0;
              state_r     <= IDLE;
            end else begin
              act_row_o  <= row_sel_s;
              act_data_o <= req_row_s;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_collector.sv
// Self-checking bench for psum_collector: FIFO model, arithmetic reference, per-cycle compare.
module tb_psum_collector;

  localparam int PW   = diff_demo_pkg::PSUM_WIDTH;
  localparam int NE   = 18;
  localparam int WW   = NE * PW;
  localparam int FDEP = 32;

  typedef struct {
    logic [1:0]  row;
    logic [47:0] data;
  } exp_row_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    cfg_num_pass = 8'd0;
  logic [4:0]    cfg_shift = 5'd0;
  logic          busy;
  logic          fifo_empty;
  logic [WW-1:0] fifo_dout = '0;
  logic          fifo_rd_en;
  logic          act_valid;
  logic          act_ready = 1'b1;
  logic [47:0]   act_data;
  logic [1:0]    act_row;
  logic          done;

  int checks = 0;
  int failures = 0;

  logic [WW-1:0] fmem [FDEP];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          force_empty = 1'b0;
  longint        model_sum [NE];
  exp_row_t      exp_q [$];
  int            done_cnt = 0;
  logic [47:0]   cap_row0 = '0;

  assign fifo_empty = force_empty || (wr_ptr == rd_ptr);

  always #5 clk = ~clk;

  psum_collector dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cfg_num_pass (cfg_num_pass),
    .cfg_shift    (cfg_shift),
    .busy_o       (busy),
    .fifo_empty_i (fifo_empty),
    .fifo_dout_i  (fifo_dout),
    .fifo_rd_en_o (fifo_rd_en),
    .act_valid_o  (act_valid),
    .act_ready_i  (act_ready),
    .act_data_o   (act_data),
    .act_row_o    (act_row),
    .done_o       (done)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Registered-read FIFO: data appears the cycle after a pop.
  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_dout <= fmem[rd_ptr % FDEP];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Per-cycle compare against the reference rows and the handshake/FIFO rules.
  logic        prev_rd = 1'b0;
  logic        prev_stall = 1'b0;
  logic        prev_done = 1'b0;
  logic [47:0] prev_data = '0;
  logic [1:0]  prev_row = 2'd0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rd = 1'b0; prev_stall = 1'b0; prev_done = 1'b0;
    end else begin
      if (fifo_rd_en) begin
        chk("rd_en_while_empty", {63'd0, fifo_empty}, 64'd0);
        chk("rd_en_back_to_back", {63'd0, prev_rd}, 64'd0);
        chk("rd_en_during_output", {63'd0, act_valid}, 64'd0);
      end
      if (prev_stall && act_valid) begin
        chk("stall_data_stable", {16'd0, act_data}, {16'd0, prev_data});
        chk("stall_row_stable", {62'd0, act_row}, {62'd0, prev_row});
      end
      if (act_valid && act_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_row", 64'd1, 64'd0);
        end else begin
          chk("row_index", {62'd0, act_row}, {62'd0, exp_q[0].row});
          chk("row_data", {16'd0, act_data}, {16'd0, exp_q[0].data});
          void'(exp_q.pop_front());
        end
        if (act_row == 2'd0) cap_row0 = act_data;
      end
      if (done) begin
        chk("done_single_pulse", {63'd0, prev_done}, 64'd0);
        done_cnt++;
      end
      prev_rd    = fifo_rd_en;
      prev_stall = act_valid && !act_ready;
      prev_data  = act_data;
      prev_row   = act_row;
      prev_done  = done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int k = 0; k < NE; k++) model_sum[k] = 0;
  endtask

  // Queue one tile: even columns get a, odd columns get b.
  task automatic push_word(input int a, input int b);
    logic [WW-1:0] w;
    int v;
    for (int k = 0; k < NE; k++) begin
      v = (k % 2 == 0) ? a : b;
      w[k*PW +: PW] = PW'(v);
      model_sum[k] += v;
    end
    fmem[wr_ptr % FDEP] = w;
    wr_ptr++;
  endtask

  // Reference: shift, clamp to int8, optional ReLU, for each of the 3 rows.
  task automatic expect_rows(input int sh);
    exp_row_t e;
    longint v;
    for (int r = 0; r < 3; r++) begin
      e.row = 2'(r);
      e.data = '0;
      for (int c = 0; c < 6; c++) begin
        v = model_sum[r*6 + c] >>> sh;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
`ifdef PSUM_COLLECTOR_RELU_EN
        if (v < 0) v = 0;
`endif
        e.data[c*8 +: 8] = v[7:0];
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input int np, input int sh);
    cfg_num_pass = 8'(np);
    cfg_shift = 5'(sh);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input string nm);
    int n = 0;
    while (done_cnt < target && n < 400) begin
      tick();
      n++;
    end
    chk(nm, 64'(done_cnt), 64'(target));
  endtask

  task automatic wait_pops(input int target, input string nm);
    int n = 0;
    while (rd_ptr < target && n < 200) begin
      tick();
      n++;
    end
    chk(nm, 64'(rd_ptr), 64'(target));
  endtask

  logic [47:0] sat_lit;
  logic [47:0] bp_lit;
  int p0;

  initial begin
`ifdef PSUM_COLLECTOR_RELU_EN
    sat_lit = 48'h007F007F007F;
    bp_lit  = 48'h000100010001;
`else
    sat_lit = 48'h807F807F807F;
    bp_lit  = 48'hEC01EC01EC01;
`endif
    // Reset state
    repeat (3) tick();
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    chk("reset_valid", {63'd0, act_valid}, 64'd0);
    chk("reset_data", {16'd0, act_data}, 64'd0);
    chk("reset_row", {62'd0, act_row}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Single pass, all elements 5
    clear_model(); push_word(5, 5); expect_rows(0);
    chk("model_pin_single", {16'd0, exp_q[0].data}, {16'd0, 48'h050505050505});
    p0 = rd_ptr;
    pulse_start(1, 0);
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    wait_done(1, "single_done");
    chk("single_pops", 64'(rd_ptr - p0), 64'd1);
    chk("single_row0_lit", {16'd0, cap_row0}, {16'd0, 48'h050505050505});
    tick();
    chk("busy_after_done", {63'd0, busy}, 64'd0);

    // Three passes of 100 fed slowly, shift 2
    clear_model(); push_word(100, 100); push_word(100, 100); push_word(100, 100);
    wr_ptr = wr_ptr - 2;  // hold back the last two words; model already holds their sum
    expect_rows(2);
    chk("model_pin_accum", {16'd0, exp_q[0].data}, {16'd0, 48'h4B4B4B4B4B4B});
    p0 = rd_ptr;
    pulse_start(3, 2);
    repeat (8) tick(); wr_ptr++;
    repeat (8) tick(); wr_ptr++;
    wait_done(2, "accum_done");
    chk("accum_pops", 64'(rd_ptr - p0), 64'd3);
    chk("accum_row0_lit", {16'd0, cap_row0}, {16'd0, 48'h4B4B4B4B4B4B});

    // Saturation both ways
    clear_model(); push_word(5000, -5000); expect_rows(0);
    chk("model_pin_sat", {16'd0, exp_q[0].data}, {16'd0, sat_lit});
    pulse_start(0, 0);  // 0 passes behaves as 1
    wait_done(3, "sat_done");
    chk("sat_row0_lit", {16'd0, cap_row0}, {16'd0, sat_lit});

    // Back-pressure on row 1
    clear_model(); push_word(3, -40); expect_rows(1);
    chk("model_pin_bp", {16'd0, exp_q[0].data}, {16'd0, bp_lit});
    p0 = rd_ptr;
    act_ready = 1'b0;
    pulse_start(1, 1);
    for (int n = 0; n < 100 && !act_valid; n++) tick();
    chk("bp_valid_seen", {63'd0, act_valid}, 64'd1);
    act_ready = 1'b1; tick();
    act_ready = 1'b0;
    chk("bp_row1_presented", {62'd0, act_row}, 64'd1);
    repeat (4) tick();
    act_ready = 1'b1;
    wait_done(4, "bp_done");
    chk("bp_pops", 64'(rd_ptr - p0), 64'd1);
    chk("bp_row0_lit", {16'd0, cap_row0}, {16'd0, bp_lit});

    // Empty stall between passes
    clear_model(); push_word(10, 10);
    p0 = rd_ptr;
    pulse_start(2, 0);
    wait_pops(p0 + 1, "stall_first_pop");
    force_empty = 1'b1;
    push_word(20, 20); expect_rows(0);
    repeat (10) tick();
    chk("stall_no_pop", 64'(rd_ptr - p0), 64'd1);
    chk("stall_busy", {63'd0, busy}, 64'd1);
    chk("stall_no_valid", {63'd0, act_valid}, 64'd0);
    force_empty = 1'b0;
    wait_done(5, "stall_done");
    chk("stall_row0_lit", {16'd0, cap_row0}, {16'd0, 48'h1E1E1E1E1E1E});

    // Reset after pass 1 of 2, then a fresh single pass of 7
    clear_model(); push_word(50, 50);
    p0 = rd_ptr;
    pulse_start(2, 0);
    wait_pops(p0 + 1, "rst_first_pop");
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_valid", {63'd0, act_valid}, 64'd0);
    chk("rst_data", {16'd0, act_data}, 64'd0);
    chk("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    clear_model(); push_word(7, 7); expect_rows(0);
    pulse_start(1, 0);
    wait_done(6, "rst_new_done");
    chk("rst_row0_lit", {16'd0, cap_row0}, {16'd0, 48'h070707070707});

    repeat (3) tick();
    chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
